// File: rtl/nw_align_collector.sv
// Captures the NW kernel's alignedA/alignedB writes and, after kernel_done, streams {A,B} byte pairs.
// First beat registered one cycle after kernel_done; 1 beat/cycle, beats held while m_valid & !m_ready.
module nw_align_collector #(
  parameter int         DEPTH  = 256,
  parameter int         ADDR_W = 16,
  parameter logic [7:0] FILL   = 8'h5F
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] alignedA_address0,
  input  logic              alignedA_ce0,
  input  logic              alignedA_we0,
  input  logic [7:0]        alignedA_d0,
  input  logic [ADDR_W-1:0] alignedB_address0,
  input  logic              alignedB_ce0,
  input  logic              alignedB_we0,
  input  logic [7:0]        alignedB_d0,
  input  logic              kernel_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       m_data,
  output logic              m_last,
  output logic              busy,
  output logic              job_done,
  output logic              err_oob,
  output logic              err_overrun
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic {CAPTURE, DRAIN} state_t;

  state_t           state;
  logic [7:0]       mem_a [DEPTH];
  logic [7:0]       mem_b [DEPTH];
  logic [DEPTH-1:0] mask_a, mask_b;
  logic [CNT_W-1:0] max_a, max_b, len;
  logic [IDX_W-1:0] k;

  logic             wr_a, wr_b, in_a, in_b, wa_ok, wb_ok;
  logic [IDX_W-1:0] a_idx, b_idx, k_nxt;
  logic [CNT_W-1:0] a_end, b_end, max_a_nx, max_b_nx, len_nx;
  logic [7:0]       beat0_a, beat0_b, nxt_a, nxt_b;

  function automatic logic [7:0] pick(input logic m, input logic [7:0] d);
    return m ? d : FILL;
  endfunction

  assign wr_a  = alignedA_ce0 & alignedA_we0;
  assign wr_b  = alignedB_ce0 & alignedB_we0;
  assign in_a  = alignedA_address0 < DEPTH_A;
  assign in_b  = alignedB_address0 < DEPTH_A;
  assign wa_ok = (state == CAPTURE) & wr_a & in_a;
  assign wb_ok = (state == CAPTURE) & wr_b & in_b;
  assign a_idx = alignedA_address0[IDX_W-1:0];
  assign b_idx = alignedB_address0[IDX_W-1:0];
  assign a_end = {1'b0, a_idx} + CNT_W'(1);
  assign b_end = {1'b0, b_idx} + CNT_W'(1);

  // Length and first beat include a write landing in the same cycle as kernel_done.
  assign max_a_nx = (wa_ok && a_end > max_a) ? a_end : max_a;
  assign max_b_nx = (wb_ok && b_end > max_b) ? b_end : max_b;
  assign len_nx   = (max_a_nx > max_b_nx) ? max_a_nx : max_b_nx;
  assign beat0_a  = (wa_ok && a_idx == '0) ? alignedA_d0 : pick(mask_a[0], mem_a[0]);
  assign beat0_b  = (wb_ok && b_idx == '0) ? alignedB_d0 : pick(mask_b[0], mem_b[0]);

  assign k_nxt = k + IDX_W'(1);
  assign nxt_a = pick(mask_a[k_nxt], mem_a[k_nxt]);
  assign nxt_b = pick(mask_b[k_nxt], mem_b[k_nxt]);

  always_ff @(posedge ap_clk) begin
    if (wa_ok) mem_a[a_idx] <= alignedA_d0;
    if (wb_ok) mem_b[b_idx] <= alignedB_d0;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= CAPTURE;
      mask_a      <= '0;
      mask_b      <= '0;
      max_a       <= '0;
      max_b       <= '0;
      len         <= '0;
      k           <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= 16'h0000;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      err_oob     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        CAPTURE: begin
          if (wa_ok) mask_a[a_idx] <= 1'b1;
          if (wb_ok) mask_b[b_idx] <= 1'b1;
          max_a <= max_a_nx;
          max_b <= max_b_nx;
          if ((wr_a && !in_a) || (wr_b && !in_b)) err_oob <= 1'b1;
          if (kernel_done) begin
            if (len_nx == '0) begin
              job_done <= 1'b1;
            end else begin
              state   <= DRAIN;
              busy    <= 1'b1;
              m_valid <= 1'b1;
              len     <= len_nx;
              k       <= '0;
              m_data  <= {beat0_a, beat0_b};
              m_last  <= (len_nx == CNT_W'(1));
            end
          end
        end
        DRAIN: begin
          if (wr_a || wr_b || kernel_done) err_overrun <= 1'b1;
          if (m_valid && m_ready) begin
            if (m_last) begin
              state    <= CAPTURE;
              busy     <= 1'b0;
              m_valid  <= 1'b0;
              m_last   <= 1'b0;
              job_done <= 1'b1;
              mask_a   <= '0;
              mask_b   <= '0;
              max_a    <= '0;
              max_b    <= '0;
            end else begin
              k      <= k_nxt;
              m_data <= {nxt_a, nxt_b};
              m_last <= ({1'b0, k_nxt} == len - CNT_W'(1));
            end
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_nw_align_collector.sv
// Directed bench for nw_align_collector: reference byte arrays model the expected drain stream.
module tb_nw_align_collector;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [15:0] alignedA_address0, alignedB_address0;
  logic        alignedA_ce0, alignedA_we0, alignedB_ce0, alignedB_we0;
  logic [7:0]  alignedA_d0, alignedB_d0;
  logic        kernel_done, m_valid, m_ready, m_last, busy, job_done, err_oob, err_overrun;
  logic [15:0] m_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  logic [7:0] ea [256];
  logic [7:0] eb [256];
  bit         va [256];
  bit         vb [256];
  int         maxa, maxb;

  nw_align_collector dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .alignedA_address0(alignedA_address0), .alignedA_ce0(alignedA_ce0),
    .alignedA_we0(alignedA_we0), .alignedA_d0(alignedA_d0),
    .alignedB_address0(alignedB_address0), .alignedB_ce0(alignedB_ce0),
    .alignedB_we0(alignedB_we0), .alignedB_d0(alignedB_d0),
    .kernel_done(kernel_done), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .job_done(job_done),
    .err_oob(err_oob), .err_overrun(err_overrun)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 256; i++) begin
      va[i] = 1'b0;
      vb[i] = 1'b0;
    end
    maxa = 0;
    maxb = 0;
  endtask

  function automatic logic [15:0] exp_beat(input int k);
    return {va[k] ? ea[k] : 8'h5F, vb[k] ? eb[k] : 8'h5F};
  endfunction

  function automatic int mlen();
    return (maxa > maxb) ? maxa : maxb;
  endfunction

  task automatic idle_inputs;
    alignedA_ce0 = 1'b0; alignedA_we0 = 1'b0; alignedA_address0 = '0; alignedA_d0 = '0;
    alignedB_ce0 = 1'b0; alignedB_we0 = 1'b0; alignedB_address0 = '0; alignedB_d0 = '0;
    kernel_done = 1'b0;
  endtask

  // One capture-phase cycle: optional A/B writes plus optional kernel_done.
  task automatic step(input bit a_en, input int a_addr, input logic [7:0] a_d,
                      input bit b_en, input int b_addr, input logic [7:0] b_d, input bit done);
    alignedA_ce0 = a_en; alignedA_we0 = a_en; alignedA_address0 = 16'(a_addr); alignedA_d0 = a_d;
    alignedB_ce0 = b_en; alignedB_we0 = b_en; alignedB_address0 = 16'(b_addr); alignedB_d0 = b_d;
    kernel_done = done;
    if (a_en && a_addr < 256) begin
      ea[a_addr] = a_d; va[a_addr] = 1'b1;
      if (a_addr + 1 > maxa) maxa = a_addr + 1;
    end
    if (b_en && b_addr < 256) begin
      eb[b_addr] = b_d; vb[b_addr] = 1'b1;
      if (b_addr + 1 > maxb) maxb = b_addr + 1;
    end
    tick;
    idle_inputs;
  endtask

  task automatic drain(input int n, input bit rnd, output int ncyc);
    int k;
    logic [15:0] held;
    bit stalled;
    k = 0; ncyc = 0; stalled = 1'b0; held = '0;
    while (k < n && ncyc < 4000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("beat_valid", 32'(m_valid), 32'd1);
      check("beat_data", 32'(m_data), 32'(exp_beat(k)));
      check("beat_last", 32'(m_last), 32'(k == n - 1));
      if (stalled) check("stall_hold", 32'(m_data), 32'(held));
      held = m_data;
      stalled = !m_ready;
      tick;
      if (!stalled) k++;
      ncyc++;
    end
    check("drain_count", 32'(k), 32'(n));
    check("end_job_done", 32'(job_done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
  endtask

  initial begin
    idle_inputs;
    m_ready = 1'b1;
    clear_model;

    #12;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_job_done", 32'(job_done), 32'd0);
    check("rst_err_oob", 32'(err_oob), 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    check("rst_data", 32'(m_data), 32'h0000);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick;

    // Full-length job, continuous ready.
    for (int i = 0; i < 256; i++) step(1'b1, i, 8'(8'h61 + i % 4), 1'b1, i, 8'h63, 1'b0);
    check("full_len", 32'(mlen()), 32'd256);
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    check("full_busy", 32'(busy), 32'd1);
    check("full_beat0", 32'(m_data), 32'h6163);
    drain(256, 1'b0, cyc);
    check("full_job_done_cycle", 32'(cyc + 1), 32'd257);
    tick;
    check("full_job_done_pulse", 32'(job_done), 32'd0);
    clear_model;

    // Sparse, unequal lengths.
    for (int i = 0; i < 10; i++) step(1'b1, i, 8'(8'h30 + i), i < 5, i, 8'(8'h40 + i), 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    check("sparse_beat5", 32'(exp_beat(5)), 32'h355F);
    drain(10, 1'b0, cyc);
    clear_model;

    // Backpressure on the full job.
    for (int i = 0; i < 256; i++) step(1'b1, i, 8'(8'h61 + i % 4), 1'b1, i, 8'h63, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    drain(256, 1'b1, cyc);
    clear_model;

    // Out-of-range write: flagged, ignored, length unaffected.
    step(1'b1, 256, 8'hAA, 1'b1, 16'hFFFF, 8'hBB, 1'b0);
    check("oob_flag", 32'(err_oob), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, i, 8'(8'h10 + i), 1'b0, 0, 8'h00, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    drain(3, 1'b0, cyc);
    clear_model;

    // Zero-length job.
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    check("zero_job_done", 32'(job_done), 32'd1);
    check("zero_valid", 32'(m_valid), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    tick;
    check("zero_job_done_clear", 32'(job_done), 32'd0);
    check("zero_valid_after", 32'(m_valid), 32'd0);

    // Write in the same cycle as kernel_done is included.
    step(1'b1, 0, 8'h70, 1'b0, 0, 8'h00, 1'b0);
    step(1'b1, 1, 8'h71, 1'b0, 0, 8'h00, 1'b0);
    step(1'b1, 4, 8'h77, 1'b1, 2, 8'h88, 1'b1);
    check("same_cycle_len", 32'(mlen()), 32'd5);
    drain(5, 1'b0, cyc);
    clear_model;

    // Overrun: write and kernel_done during DRAIN are ignored but flagged.
    for (int i = 0; i < 4; i++) step(1'b1, i, 8'(8'h20 + i), 1'b0, 0, 8'h00, 1'b0);
    m_ready = 1'b0;
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    alignedA_ce0 = 1'b1; alignedA_we0 = 1'b1; alignedA_address0 = 16'd0; alignedA_d0 = 8'hEE;
    kernel_done = 1'b1;
    tick;
    idle_inputs;
    check("overrun_flag", 32'(err_overrun), 32'd1);
    check("overrun_valid", 32'(m_valid), 32'd1);
    check("overrun_data", 32'(m_data), 32'h205F);
    drain(4, 1'b0, cyc);
    clear_model;

    // Asynchronous reset mid-DRAIN.
    for (int i = 0; i < 8; i++) step(1'b1, i, 8'(8'h41 + i), 1'b1, i, 8'h2D, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    tick;
    tick;
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_overrun_sticky", 32'(err_overrun), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(err_overrun), 32'd0);
    check("mid_rst_oob", 32'(err_oob), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick;
    clear_model;
    for (int i = 0; i < 3; i++) step(1'b1, i, 8'(8'h51 + i), 1'b1, i, 8'(8'h61 + i), 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 0, 8'h00, 1'b1);
    drain(3, 1'b0, cyc);
    tick;
    check("post_rst_idle_valid", 32'(m_valid), 32'd0);
    check("post_rst_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
